multicycle_control: RTL and testbench

//  Multi-cycle control unit for the reduced RISC-V core. It is the sequential

---
 rtl/control_pkg.sv | 83 ++++++++
 rtl/instr_decoder.sv | 60 ++++++
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, instruction
// classes, RV32 opcode/funct fields and the datapath control codes.
package control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_WB_ALU,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_MEM,
        ST_BRANCH,
        ST_JUMP,
        ST_WB_IMM,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_LUI,
        CL_BAD
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    // Returns {supported, alu_op} for the fn3 values shared by R and I ALU ops.
    function automatic logic [3:0] alu_from_fn3(input logic [2:0] fn3);
        case (fn3)
            F3_ADD:  return {1'b1, ALU_ADD};
            F3_SLT:  return {1'b1, ALU_SLT};
            F3_XOR:  return {1'b1, ALU_XOR};
            F3_OR:   return {1'b1, ALU_OR};
            F3_AND:  return {1'b1, ALU_AND};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational classifier: maps the instruction register to an instruction
// class, the ALU operation for ALU classes, and a legality flag.
module instr_decoder
    import control_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic [ADDRESS_WIDTH-1:0] i_instr,
    output iclass_t                  o_class,
    output logic [2:0]               o_alu_op,
    output logic                     o_legal,
    output logic                     o_is_bne
);

    logic [6:0] w_opc;
    logic [2:0] w_fn3;
    logic [6:0] w_fn7;
    logic [3:0] w_fn_alu;
    logic       w_unused_fields;

    assign w_opc    = i_instr[6:0];
    assign w_fn3    = i_instr[14:12];
    assign w_fn7    = i_instr[31:25];
    assign w_fn_alu = alu_from_fn3(w_fn3);

    // Register specifiers are irrelevant to control.
    assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7]};

    always_comb begin
        o_class  = CL_BAD;
        o_alu_op = ALU_ADD;
        case (w_opc)
            OP_R: begin
                if (w_fn7 == F7_BASE && w_fn_alu[3]) begin
                    o_class  = CL_R;
                    o_alu_op = w_fn_alu[2:0];
                end else if (w_fn7 == F7_ALT && w_fn3 == F3_ADD) begin
                    o_class  = CL_R;
                    o_alu_op = ALU_SUB;
                end
            end
            OP_I: begin
                if (w_fn_alu[3]) begin
                    o_class  = CL_I;
                    o_alu_op = w_fn_alu[2:0];
                end
            end
            OP_LOAD:   if (w_fn3 == F3_LW) o_class = CL_LOAD;
            OP_STORE:  if (w_fn3 == F3_SW) o_class = CL_STORE;
            OP_BRANCH: if (w_fn3 == F3_BEQ || w_fn3 == F3_BNE) o_class = CL_BRANCH;
            OP_JAL:    o_class = CL_JAL;
            OP_LUI:    o_class = CL_LUI;
            default:   o_class = CL_BAD;
        endcase
    end

    assign o_legal  = (o_class != CL_BAD);
    assign o_is_bne = (w_fn3 == F3_BNE);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 subset control FSM: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath enables.
module multicycle_control
    import control_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned ALU_CTRL_WIDTH = 3,
    parameter int unsigned IMM_SRC_WIDTH  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDRESS_WIDTH-1:0]  instr,
    input  logic                      EQ,
    input  logic                      mem_ready,
    output logic                      IRWrite,
    output logic                      PCWrite,
    output logic                      PCsrc,
    output logic                      RegWrite,
    output logic                      MemRead,
    output logic                      MemWrite,
    output logic [ALU_CTRL_WIDTH-1:0] ALUctrl,
    output logic                      ALUsrc,
    output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
    output logic [1:0]                ResultSrc,
    output logic                      illegal
);

    state_t     r_state;
    state_t     w_next;
    iclass_t    w_class;
    logic [2:0] w_alu_op;
    logic       w_legal;
    logic       w_is_bne;
    logic [2:0] w_alu;
    logic [2:0] w_imm;
    logic       w_taken;

    instr_decoder #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_dec (
        .i_instr  (instr),
        .o_class  (w_class),
        .o_alu_op (w_alu_op),
        .o_legal  (w_legal),
        .o_is_bne (w_is_bne)
    );

    // EQ is asserted when the operands differ.
    assign w_taken = w_is_bne ? EQ : ~EQ;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUsrc    = 1'b0;
        ResultSrc = RES_ALU;
        illegal   = 1'b0;
        w_alu     = ALU_ADD;
        w_imm     = IMM_I;
        case (r_state)
            ST_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                w_next  = ST_DECODE;
            end
            ST_DECODE: begin
                if (!w_legal) begin
                    w_next = ST_TRAP;
                end else begin
                    case (w_class)
                        CL_R:      w_next = ST_EXEC_R;
                        CL_I:      w_next = ST_EXEC_I;
                        CL_LOAD:   w_next = ST_MEM_ADDR;
                        CL_STORE:  begin w_next = ST_MEM_ADDR; w_imm = IMM_S; end
                        CL_BRANCH: begin w_next = ST_BRANCH;   w_imm = IMM_B; end
                        CL_JAL:    begin w_next = ST_JUMP;     w_imm = IMM_J; end
                        CL_LUI:    begin w_next = ST_WB_IMM;   w_imm = IMM_U; end
                        default:   w_next = ST_TRAP;
                    endcase
                end
            end
            ST_EXEC_R: begin
                w_alu  = w_alu_op;
                w_next = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                ALUsrc = 1'b1;
                w_alu  = w_alu_op;
                w_next = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                RegWrite = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                ALUsrc = 1'b1;
                if (w_class == CL_STORE) begin
                    w_imm  = IMM_S;
                    w_next = ST_MEM_WR;
                end else begin
                    w_next = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                MemRead = 1'b1;
                if (mem_ready) w_next = ST_WB_MEM;
            end
            ST_MEM_WR: begin
                MemWrite = 1'b1;
                if (mem_ready) w_next = ST_FETCH;
            end
            ST_WB_MEM: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_MEM;
                w_next    = ST_FETCH;
            end
            ST_BRANCH: begin
                w_alu   = ALU_SUB;
                w_imm   = IMM_B;
                PCWrite = w_taken;
                PCsrc   = w_taken;
                w_next  = ST_FETCH;
            end
            ST_JUMP: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_PC4;
                w_imm     = IMM_J;
                PCWrite   = 1'b1;
                PCsrc     = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_WB_IMM: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_IMM;
                w_imm     = IMM_U;
                w_next    = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: w_next = ST_FETCH;
        endcase

        // Reset overrides the Moore decode so in-flight requests drop immediately.
        if (rst) begin
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            PCsrc     = 1'b0;
            RegWrite  = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            ALUsrc    = 1'b0;
            ResultSrc = RES_ALU;
            illegal   = 1'b0;
            w_alu     = ALU_ADD;
            w_imm     = IMM_I;
        end
    end

    assign ALUctrl = ALU_CTRL_WIDTH'(w_alu);
    assign ImmSrc  = IMM_SRC_WIDTH'(w_imm);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: every cycle's full output
// vector is compared against a hand-built expectation.
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        EQ;
    logic        mem_ready;
    logic        IRWrite, PCWrite, PCsrc, RegWrite, MemRead, MemWrite;
    logic [2:0]  ALUctrl;
    logic        ALUsrc;
    logic [2:0]  ImmSrc;
    logic [1:0]  ResultSrc;
    logic        illegal;

    int unsigned n_vec;
    int unsigned n_err;

    multicycle_control #(
        .ADDRESS_WIDTH  (32),
        .ALU_CTRL_WIDTH (3),
        .IMM_SRC_WIDTH  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .EQ        (EQ),
        .mem_ready (mem_ready),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .PCsrc     (PCsrc),
        .RegWrite  (RegWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUctrl   (ALUctrl),
        .ALUsrc    (ALUsrc),
        .ImmSrc    (ImmSrc),
        .ResultSrc (ResultSrc),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed as {IR,PCW,PCs,RW,MR,MW,ALU[2:0],ALUsrc,Imm[2:0],Res[1:0],ill}.
    function automatic logic [15:0] ov(input logic ir, input logic pcw, input logic pcs,
                                       input logic rw, input logic mr, input logic mw,
                                       input logic [2:0] alu, input logic as,
                                       input logic [2:0] imm, input logic [1:0] res,
                                       input logic ill);
        return {ir, pcw, pcs, rw, mr, mw, alu, as, imm, res, ill};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs are set by the caller at a negedge; outputs are checked 1ns later,
    // then time advances to the next negedge (one full cycle).
    task automatic cyc(input string tag, input logic [15:0] exp);
        #1;
        chk(tag, {IRWrite, PCWrite, PCsrc, RegWrite, MemRead, MemWrite,
                  ALUctrl, ALUsrc, ImmSrc, ResultSrc, illegal}, exp);
        @(negedge clk);
    endtask

    logic [15:0] V_ZERO, V_FETCH, V_WB_ALU;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        instr     = 32'h0000_0013;
        EQ        = 1'b0;
        mem_ready = 1'b0;
        V_ZERO    = '0;
        V_FETCH   = ov(1,1,0,0,0,0,3'b000,0,3'b000,2'b00,0);
        V_WB_ALU  = ov(0,0,0,1,0,0,3'b000,0,3'b000,2'b00,0);
        @(negedge clk);

        cyc("reset_c1", V_ZERO);
        cyc("reset_c2", V_ZERO);
        rst = 1'b0;

        // ADDI x1,x0,5
        instr = 32'h0050_0093;
        cyc("addi_fetch",  V_FETCH);
        cyc("addi_decode", V_ZERO);
        cyc("addi_exec",   ov(0,0,0,0,0,0,3'b000,1,3'b000,2'b00,0));
        cyc("addi_wb",     V_WB_ALU);

        // BNE with EQ=1 (operands differ) -> taken
        instr = 32'h0020_9463;
        EQ    = 1'b1;
        cyc("bne_t_fetch",  V_FETCH);
        cyc("bne_t_decode", ov(0,0,0,0,0,0,3'b000,0,3'b010,2'b00,0));
        cyc("bne_t_branch", ov(0,1,1,0,0,0,3'b001,0,3'b010,2'b00,0));

        // BNE with EQ=0 -> not taken
        EQ = 1'b0;
        cyc("bne_n_fetch",  V_FETCH);
        cyc("bne_n_decode", ov(0,0,0,0,0,0,3'b000,0,3'b010,2'b00,0));
        cyc("bne_n_branch", ov(0,0,0,0,0,0,3'b001,0,3'b010,2'b00,0));

        // BEQ with EQ=0 -> taken, then EQ=1 -> not taken
        instr = 32'h0020_8463;
        cyc("beq_t_fetch",  V_FETCH);
        cyc("beq_t_decode", ov(0,0,0,0,0,0,3'b000,0,3'b010,2'b00,0));
        cyc("beq_t_branch", ov(0,1,1,0,0,0,3'b001,0,3'b010,2'b00,0));
        EQ = 1'b1;
        cyc("beq_n_fetch",  V_FETCH);
        cyc("beq_n_decode", ov(0,0,0,0,0,0,3'b000,0,3'b010,2'b00,0));
        cyc("beq_n_branch", ov(0,0,0,0,0,0,3'b001,0,3'b010,2'b00,0));
        EQ = 1'b0;

        // SUB x3,x1,x2 and AND x3,x1,x2
        instr = 32'h4020_81B3;
        cyc("sub_fetch",  V_FETCH);
        cyc("sub_decode", V_ZERO);
        cyc("sub_exec",   ov(0,0,0,0,0,0,3'b001,0,3'b000,2'b00,0));
        cyc("sub_wb",     V_WB_ALU);
        instr = 32'h0020_F1B3;
        cyc("and_fetch",  V_FETCH);
        cyc("and_decode", V_ZERO);
        cyc("and_exec",   ov(0,0,0,0,0,0,3'b010,0,3'b000,2'b00,0));
        cyc("and_wb",     V_WB_ALU);

        // LW with two wait cycles: 7 cycles total
        instr = 32'h0000_A183;
        cyc("lw_fetch",  V_FETCH);
        cyc("lw_decode", V_ZERO);
        mem_ready = 1'b1;  // ignored outside the memory states
        cyc("lw_addr",   ov(0,0,0,0,0,0,3'b000,1,3'b000,2'b00,0));
        mem_ready = 1'b0;
        cyc("lw_rd_w1",  ov(0,0,0,0,1,0,3'b000,0,3'b000,2'b00,0));
        cyc("lw_rd_w2",  ov(0,0,0,0,1,0,3'b000,0,3'b000,2'b00,0));
        mem_ready = 1'b1;
        cyc("lw_rd_ok",  ov(0,0,0,0,1,0,3'b000,0,3'b000,2'b00,0));
        mem_ready = 1'b0;
        cyc("lw_wb",     ov(0,0,0,1,0,0,3'b000,0,3'b000,2'b01,0));

        // SW with mem_ready on entry: single-cycle write, back to FETCH
        instr = 32'h0020_A023;
        cyc("sw_fetch",  V_FETCH);
        cyc("sw_decode", ov(0,0,0,0,0,0,3'b000,0,3'b001,2'b00,0));
        cyc("sw_addr",   ov(0,0,0,0,0,0,3'b000,1,3'b001,2'b00,0));
        mem_ready = 1'b1;
        cyc("sw_wr",     ov(0,0,0,0,0,1,3'b000,0,3'b000,2'b00,0));
        mem_ready = 1'b0;

        // JAL then LUI
        instr = 32'h0080_006F;
        cyc("sw_next_fetch", V_FETCH);
        cyc("jal_decode",    ov(0,0,0,0,0,0,3'b000,0,3'b011,2'b00,0));
        cyc("jal_jump",      ov(0,1,1,1,0,0,3'b000,0,3'b011,2'b10,0));
        instr = 32'h0000_12B7;
        cyc("lui_fetch",  V_FETCH);
        cyc("lui_decode", ov(0,0,0,0,0,0,3'b000,0,3'b100,2'b00,0));
        cyc("lui_wb",     ov(0,0,0,1,0,0,3'b000,0,3'b100,2'b11,0));

        // Unknown opcode -> TRAP, sticky for 20 cycles regardless of inputs
        instr = 32'h0000_007F;
        cyc("bad_op_fetch",  V_FETCH);
        cyc("bad_op_decode", V_ZERO);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            EQ        = i[1];
            instr     = (i == 5) ? 32'h0050_0093 : 32'h0000_007F;
            cyc($sformatf("trap_hold_%0d", i), ov(0,0,0,0,0,0,3'b000,0,3'b000,2'b00,1));
        end
        mem_ready = 1'b0;
        EQ        = 1'b0;
        rst       = 1'b1;
        cyc("trap_rst", V_ZERO);
        rst = 1'b0;

        // SUB with fn7=0000001 -> TRAP
        instr = 32'h0220_81B3;
        cyc("bad_f7_fetch",  V_FETCH);
        cyc("bad_f7_decode", V_ZERO);
        cyc("bad_f7_trap1",  ov(0,0,0,0,0,0,3'b000,0,3'b000,2'b00,1));
        cyc("bad_f7_trap2",  ov(0,0,0,0,0,0,3'b000,0,3'b000,2'b00,1));
        rst = 1'b1;
        cyc("bad_f7_rst", V_ZERO);
        rst = 1'b0;

        // Reset on the second MEM_RD wait cycle
        instr = 32'h0000_A183;
        cyc("lwr_fetch",  V_FETCH);
        cyc("lwr_decode", V_ZERO);
        cyc("lwr_addr",   ov(0,0,0,0,0,0,3'b000,1,3'b000,2'b00,0));
        cyc("lwr_rd_w1",  ov(0,0,0,0,1,0,3'b000,0,3'b000,2'b00,0));
        rst = 1'b1;
        cyc("lwr_rd_rst", V_ZERO);
        rst = 1'b0;
        cyc("lwr_refetch", V_FETCH);
        cyc("lwr_redecode", V_ZERO);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
